// File: rtl/palette_pkg.sv
// Shared types and constants for the palette RAM video-side consumer.
package palette_pkg;

    localparam int PAL_ADDR_W = 8;
    localparam int PAL_DATA_W = 16;
    localparam int RGB_W      = 12;

    // One palette entry's colour payload, MSB first: {r, g, b}.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // CPU readback sequencer: issue address, wait for RAM data, pulse ack.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } pal_cpu_state_t;

    // Bits 15:12 of a palette entry carry no colour and are dropped here.
    function automatic rgb444_t entry_to_rgb(input logic [PAL_DATA_W-1:0] entry);
        return rgb444_t'(entry[RGB_W-1:0]);
    endfunction

endpackage

// File: rtl/palette_lookup.sv
// Palette lookup: drives the palette RAM read port from the pixel stream,
// realigns sideband with the returned entry (latency 2), and lends free
// read slots to CPU palette readback.
//
// CPU handshake: cpu_rd_req_i is a level held (with a stable address) until
// the one-cycle cpu_rd_ack_o pulse; the requester drops it in the ack cycle.
// cpu_rd_data_o is valid in the ack cycle and held until the next ack.
module palette_lookup
    import palette_pkg::*;
#(
    parameter int SYNC_W = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pix_valid_i,
    input  logic [7:0]            pix_idx_i,
    input  logic                  pix_active_i,
    input  logic                  pix_border_i,
    input  logic [7:0]            border_idx_i,
    input  logic [SYNC_W-1:0]     pix_sync_i,
    output logic [7:0]            pal_rd_addr_o,
    input  logic [15:0]           pal_rd_data_i,
    input  logic                  cpu_rd_req_i,
    input  logic [7:0]            cpu_rd_addr_i,
    output logic                  cpu_rd_ack_o,
    output logic [15:0]           cpu_rd_data_o,
    output logic                  valid_o,
    output logic                  active_o,
    output logic [SYNC_W-1:0]     sync_o,
    output logic [11:0]           rgb_o
);

    pal_cpu_state_t state_q;
    pal_cpu_state_t state_d;

    logic              video_owned;
    logic              cpu_issue;

    // First pipeline stage: sideband for the slot whose entry the RAM is
    // reading right now.
    logic              valid_s1;
    logic              active_s1;
    logic              owned_s1;
    logic [SYNC_W-1:0] sync_s1;

    rgb444_t           rgb_q;

    // Video always wins the read port; the CPU only issues in a free slot
    // from IDLE. Reset blocks issue so nothing is driven while held in reset.
    assign video_owned = pix_valid_i && (pix_active_i || pix_border_i);
    assign cpu_issue   = (state_q == IDLE) && cpu_rd_req_i && !video_owned && !rst_i;

    // CPU FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // CPU FSM next-state: one cycle in WAIT for the RAM, one cycle in ACK.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpu_issue) state_d = WAIT;
            WAIT:    state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // CPU FSM outputs and read-address mux (one owner per RAM cycle).
    always_comb begin
        cpu_rd_ack_o  = 1'b0;
        pal_rd_addr_o = 8'h00;
        if (state_q == ACK) begin
            cpu_rd_ack_o = 1'b1;
        end
        if (video_owned) begin
            pal_rd_addr_o = pix_active_i ? pix_idx_i : border_idx_i;
        end else if (cpu_issue) begin
            pal_rd_addr_o = cpu_rd_addr_i;
        end
    end

    // Capture the RAM word for the CPU while in WAIT; hold it until the next read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cpu_rd_data_o <= 16'h0000;
        end else if (state_q == WAIT) begin
            cpu_rd_data_o <= pal_rd_data_i;
        end
    end

    // Stage 1 of the sideband delay line, aligned with RAM read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_s1  <= 1'b0;
            active_s1 <= 1'b0;
            owned_s1  <= 1'b0;
            sync_s1   <= '0;
        end else begin
            valid_s1  <= pix_valid_i;
            active_s1 <= pix_active_i;
            owned_s1  <= video_owned;
            sync_s1   <= pix_sync_i;
        end
    end

    // Stage 2: output registers; colour is blanked unless the slot owned the port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o  <= 1'b0;
            active_o <= 1'b0;
            sync_o   <= '0;
            rgb_q    <= '0;
        end else begin
            valid_o  <= valid_s1;
            active_o <= active_s1;
            sync_o   <= sync_s1;
            rgb_q    <= owned_s1 ? entry_to_rgb(pal_rd_data_i) : '0;
        end
    end

    assign rgb_o = rgb_q;

endmodule

// File: tb/tb_palette_lookup.sv
// Bench for palette_lookup with a behavioural palette RAM and a cycle-level
// reference model of port ownership, output alignment and CPU readback.
module tb_palette_lookup;

    localparam int SYNC_W = 2;
    localparam int W      = 1 + 1 + SYNC_W + 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              pix_valid;
    logic [7:0]        pix_idx;
    logic              pix_active;
    logic              pix_border;
    logic [7:0]        border_idx;
    logic [SYNC_W-1:0] pix_sync;
    logic [7:0]        pal_rd_addr;
    logic [15:0]       pal_rd_data;
    logic              cpu_req;
    logic [7:0]        cpu_addr;
    logic              cpu_rd_ack;
    logic [15:0]       cpu_rd_data;
    logic              valid_out;
    logic              active_out;
    logic [SYNC_W-1:0] sync_out;
    logic [11:0]       rgb_out;

    // clock / reset
    always #5 clk = ~clk;

    palette_lookup #(.SYNC_W(SYNC_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pix_valid_i   (pix_valid),
        .pix_idx_i     (pix_idx),
        .pix_active_i  (pix_active),
        .pix_border_i  (pix_border),
        .border_idx_i  (border_idx),
        .pix_sync_i    (pix_sync),
        .pal_rd_addr_o (pal_rd_addr),
        .pal_rd_data_i (pal_rd_data),
        .cpu_rd_req_i  (cpu_req),
        .cpu_rd_addr_i (cpu_addr),
        .cpu_rd_ack_o  (cpu_rd_ack),
        .cpu_rd_data_o (cpu_rd_data),
        .valid_o       (valid_out),
        .active_o      (active_out),
        .sync_o        (sync_out),
        .rgb_o         (rgb_out)
    );

    // palette RAM: registered read, 1-cycle latency, enable tied high
    logic [15:0] mem [256];
    always @(posedge clk) pal_rd_data <= mem[pal_rd_addr];

    // scoreboard and reference state
    logic [W-1:0] exp_q[$];
    int           checks    = 0;
    int           failures  = 0;
    int           cyc       = 0;
    int           issue_cyc = -1;
    logic [15:0]  issue_data;
    logic [15:0]  cpu_data_exp;
    bit           check_en  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: apply current inputs, predict, compare, advance.
    task automatic step();
        bit          owned;
        bit          busy;
        bit          issue;
        bit          exp_ack;
        logic [7:0]  vid_addr;
        logic [7:0]  exp_addr;
        logic [W-1:0] rec;
        logic [W-1:0] obs;
        owned    = pix_valid && (pix_active || pix_border);
        vid_addr = pix_active ? pix_idx : border_idx;
        exp_ack  = (issue_cyc >= 0) && (cyc == issue_cyc + 2);
        busy     = (issue_cyc >= 0) && (cyc <= issue_cyc + 2);
        if (exp_ack) cpu_req = 1'b0;
        issue    = check_en && !rst && cpu_req && !owned && !busy;
        exp_addr = owned ? vid_addr : (issue ? cpu_addr : 8'h00);
        if (exp_ack) cpu_data_exp = issue_data;
        #1;
        if (check_en) begin
            chk("rd_addr", {24'h0, pal_rd_addr}, {24'h0, exp_addr});
            chk("cpu_ack", {31'h0, cpu_rd_ack}, {31'h0, exp_ack});
            chk("cpu_data", {16'h0, cpu_rd_data}, {16'h0, cpu_data_exp});
        end
        if (exp_q.size() >= 2) begin
            rec = exp_q.pop_front();
            obs = {valid_out, active_out, sync_out, rgb_out};
            chk("video_out", {{(32-W){1'b0}}, obs}, {{(32-W){1'b0}}, rec});
        end
        if (issue) begin
            issue_cyc  = cyc;
            issue_data = mem[cpu_addr];
        end
        rec = {pix_valid, pix_active, pix_sync, owned ? mem[vid_addr][11:0] : 12'h000};
        if (rst) begin
            exp_q.delete();
            exp_q.push_back('0);
            exp_q.push_back('0);
            issue_cyc    = -1;
            cpu_data_exp = 16'h0000;
            check_en     = 1'b1;
        end else begin
            exp_q.push_back(rec);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        pix_valid  = 1'b0;
        pix_active = 1'b0;
        pix_border = 1'b0;
        pix_idx    = 8'h00;
        pix_sync   = '0;
    endtask

    initial begin
        logic [7:0] iv;
        for (int i = 0; i < 256; i++) begin
            iv     = i[7:0];
            mem[i] = {4'hF, iv[3:0], iv[7:4], iv[3:0]};
        end
        mem[8'h12] = 16'h0ABC;
        mem[8'h40] = 16'h1234;

        idle_inputs();
        border_idx = 8'h12;
        cpu_req    = 1'b0;
        cpu_addr   = 8'h00;
        rst        = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();

        // active pixel stream over every index
        for (int i = 0; i < 256; i++) begin
            pix_valid  = 1'b1;
            pix_active = 1'b1;
            pix_idx    = i[7:0];
            pix_sync   = SYNC_W'($urandom_range(0, 3));
            step();
        end
        idle_inputs();
        step();
        step();

        // border slot, then blank slot carrying sync
        pix_valid  = 1'b1;
        pix_border = 1'b1;
        step();
        pix_border = 1'b0;
        pix_sync   = 2'b10;
        step();
        idle_inputs();
        step();
        step();
        step();

        // back-to-back border and active slots
        for (int i = 0; i < 8; i++) begin
            pix_valid  = 1'b1;
            pix_border = 1'b1;
            pix_active = (i % 2) == 1;
            pix_idx    = 8'($urandom_range(0, 255));
            step();
        end
        idle_inputs();
        step();

        // CPU read during blanking
        cpu_req  = 1'b1;
        cpu_addr = 8'h40;
        for (int i = 0; i < 5; i++) step();

        // CPU request raised during 10 active pixels
        cpu_req  = 1'b1;
        cpu_addr = 8'h7F;
        for (int i = 0; i < 10; i++) begin
            pix_valid  = 1'b1;
            pix_active = 1'b1;
            pix_idx    = 8'($urandom_range(0, 255));
            step();
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) step();

        // reset while the read is in WAIT, request held throughout
        cpu_req  = 1'b1;
        cpu_addr = 8'h40;
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            pix_valid  = $urandom_range(0, 3) != 0;
            pix_active = $urandom_range(0, 2) != 0;
            pix_border = $urandom_range(0, 1) != 0;
            pix_idx    = 8'($urandom_range(0, 255));
            border_idx = 8'($urandom_range(0, 255));
            pix_sync   = SYNC_W'($urandom_range(0, 3));
            if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req  = 1'b1;
                cpu_addr = 8'($urandom_range(0, 255));
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        idle_inputs();
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/palette_lookup.md
# palette_lookup

Video-side consumer of the 256×16 palette RAM. Takes the composer's 8-bit colour-index pixel stream, drives the palette RAM read port, and realigns sync and display-enable with the returned entry. Emits 12-bit RGB444 to the video output encoder. Lends the read port to the CPU bus interface for palette readback whenever the pixel stream does not need it.

## Interface
Parameters:
- SYNC_W, 2, width of the sync bundle passed through the pipeline ({vsync, hsync} by default)

Ports:
- clk_i  in  1  single clock, shared with the palette RAM read clock
- rst_i  in  1  reset, synchronous, active-high
- pix_valid_i  in  1  pixel slot present this cycle
- pix_idx_i  in  8  colour index for an active pixel
- pix_active_i  in  1  pixel is inside the active display area
- pix_border_i  in  1  pixel is border; `border_idx_i` replaces `pix_idx_i` (ignored if `pix_active_i`=1)
- border_idx_i  in  8  border colour index
- pix_sync_i  in  SYNC_W  sync bits for this slot
- pal_rd_addr_o  out  8  palette RAM read address (combinational)
- pal_rd_data_i  in  16  palette RAM read data, registered in the RAM, 1-cycle latency
- cpu_rd_req_i  in  1  CPU palette read request (level)
- cpu_rd_addr_i  in  8  CPU read address, held stable while `cpu_rd_req_i`=1
- cpu_rd_ack_o  out  1  one-cycle pulse: `cpu_rd_data_o` valid
- cpu_rd_data_o  out  16  CPU readback data, held until the next ack
- valid_o  out  1  delayed `pix_valid_i`
- active_o  out  1  delayed `pix_active_i`
- sync_o  out  SYNC_W  delayed `pix_sync_i`
- rgb_o  out  12  {R[3:0], G[3:0], B[3:0]}

## Operation
- **Video ownership:** the cycle is video-owned when `pix_valid_i` && (`pix_active_i` || `pix_border_i`).
  - `pal_rd_addr_o` is `pix_idx_i` if `pix_active_i`, otherwise `border_idx_i`.
- **Free slot:** in any cycle that is not video-owned, the port is free.
  - `pal_rd_addr_o` is `cpu_rd_addr_i` when the CPU read is issued that cycle, otherwise 0.
- **Palette entry decode:** `rgb` = `pal_rd_data_i[11:0]`. Bits 15:12 are ignored.
- **Blanking:** `rgb_o` = 0 whenever the delayed slot was not video-owned, including invalid or blanking slots.
  - `valid_o`, `active_o` and `sync_o` still pass through unchanged.
- **CPU read FSM** (3 states):
  - IDLE: move to WAIT when `cpu_rd_req_i`=1 and the slot is free. The CPU address is driven that same cycle.
  - WAIT: capture `pal_rd_data_i` into `cpu_rd_data_o`, then move to ACK.
  - ACK: `cpu_rd_ack_o`=1 for this cycle, then move to IDLE.
- **Handshake rule:** the requester drops `cpu_rd_req_i` in the ACK cycle. A request still high in ACK is not reissued until IDLE.
- **Port contention:** exactly one owner per RAM address cycle.
  - A video-owned cycle always beats the CPU; the CPU waits, with unbounded wait during continuous active video.
  - A video-owned slot arriving while the FSM is in WAIT or ACK does not conflict, because the CPU address was already issued.

## Timing
- **Video path:** inputs sampled in cycle T.
  - RAM registers the entry at the end of T; `pal_rd_data_i` is valid during T+1.
  - Output registers load at the end of T+1, so `valid_o`/`active_o`/`sync_o`/`rgb_o` are presented in T+2.
  - Fixed latency of 2, with full throughput of one pixel per cycle.
- **Sideband pipeline:** `pix_valid_i`, `pix_active_i`, `pix_sync_i` and a video-owned flag each pass through 2 register stages, aligned exactly with `rgb_o`.
- **CPU path:** issue in T, ack pulse in T+2. Minimum request-to-ack is 2 cycles.
- **Reset values** (effective from the cycle after `rst_i` is sampled high):
  - all outputs 0, FSM IDLE, pipeline flags 0.
  - `cpu_rd_data_o` = 0.
- **Reset in mid-operation:** an in-flight CPU read is dropped with no ack. A request still held after reset is reissued from IDLE.
- **Back-to-back border and active slots:** the address selection switches every cycle with no bubble.

## Structure
- **Shared package `palette_pkg`:**
  - PAL_ADDR_W=8, PAL_DATA_W=16, RGB_W=12.
  - `rgb444_t` packed struct {r, g, b}.
  - `pal_cpu_state_t` enum {IDLE, WAIT, ACK}.
- **Sub-modules:** none. The FSM, address mux and 2-stage delay line stay in a single module.
- **Integration:** `pal_rd_addr_o` and `pal_rd_data_i` connect directly to the palette RAM read port. Its read clock is `clk_i` and its read enables are tied high.

## Test plan
- **Active pixel stream:** RAM preloaded with entry[i] = {4'hF, i[3:0], i[7:4], i[3:0]}. Drive indices 0x00..0xFF, `pix_active_i`=1 continuously → `rgb_o` = entry[idx][11:0] exactly 2 cycles later, one per cycle, and bits 15:12 never appear.
- **Border and blank slots:** `border_idx_i`=0x12, entry[0x12]=0x0ABC.
  - Border slot → `rgb_o`=0xABC.
  - Blank slot with `pix_sync_i`=2'b10 → `rgb_o`=0 and `sync_o`=2'b10 two cycles later.
- **CPU read during blanking:** `pix_valid_i`=0, request addr 0x40 where entry=0x1234 → `pal_rd_addr_o`=0x40 that cycle, ack 2 cycles later with `cpu_rd_data_o`=0x1234, ack high for exactly 1 cycle.
- **CPU contention:** request raised during 10 active pixels → no CPU address is driven and no video pixel is corrupted. The read issues on the first free cycle and acks 2 cycles later.
- **Reset mid-read:** assert `rst_i` in WAIT → no ack, and all outputs 0 in the following cycle. With the request held high, the read reissues and acks correctly after reset is released.
